keypad_scanner: RTL

- Input-side counterpart to the scanned seven-segment display driver.
- Scans a 4x4 active-low matrix keypad, one row at a time, and synchronises and debounces the column lines.
- Each accepted key press is shifted into a 32-bit hex value register, most recent digit in nibble [3:0].
- The value feeds the display driver's 32-bit data input and CPU-visible I/O, so typed digits echo on the display.

---
 rtl/kp_pkg.sv | 61 ++++++
 rtl/keypad_scanner_sync2.sv | 34 +++
 rtl/keypad_scanner.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/kp_pkg.sv
// Shared definitions for the matrix keypad scanner.
//
// Contents:
//   state_t      debounce FSM states
//   frame_t      classification of one complete four-row scan frame
//   ROWS, COLS   keypad matrix geometry
//   MAX_DIGITS   saturation point of the entered-digit counter
//   ROW_DRIVE    active-low row drive pattern for each row index
//   count_low    number of asserted bits in a column vector
//   lowest_index index of the lowest asserted bit in a column vector

package kp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        HELD,
        RELEASE
    } state_t;

    typedef enum logic [1:0] {
        NONE,
        ONE,
        MULTI
    } frame_t;

    localparam int ROWS       = 4;
    localparam int COLS       = 4;
    localparam int MAX_DIGITS = 8;

    // Row r pulls exactly row_n[r] low; all other rows float high.
    localparam logic [3:0] ROW_DRIVE [ROWS] = '{
        4'b1110,
        4'b1101,
        4'b1011,
        4'b0111
    };

    function automatic logic [2:0] count_low(input logic [3:0] bits);
        logic [2:0] total;
        total = 3'd0;
        for (int i = 0; i < COLS; i++) begin
            total = total + {2'b00, bits[i]};
        end
        return total;
    endfunction

    // Only meaningful when exactly one bit is set; a clean single press
    // is the only case where the resulting index is used.
    function automatic logic [1:0] lowest_index(input logic [3:0] bits);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (bits[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchroniser for asynchronous level inputs.
//
// Parameters:
//   WIDTH      number of independent bits synchronised
//   RESET_VAL  value both stages take during reset
// Ports:
//   clk  input         destination clock
//   rst  input         asynchronous, active-high reset
//   d    input  WIDTH  asynchronous input
//   q    output WIDTH  synchronised copy of d, two clk edges late

module sync2 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with frame-based debounce.
//
// One row is driven low at a time for SCAN_DIV cycles. The synchronised
// columns are sampled on the last cycle of each row period, and the four
// row samples of a frame are merged into a NONE / ONE / MULTI result.
// A debounce FSM stepped once per frame accepts a key after DEBOUNCE
// identical single-key frames and waits for DEBOUNCE empty frames before
// it will accept again. Accepted digits are shifted into value.
//
// Parameters:
//   SCAN_DIV  clk cycles each row is driven (>= 4)
//   DEBOUNCE  identical frames needed to accept a press or a release (>= 1)
// Ports:
//   clk          input      system clock
//   rst          input      asynchronous, active-high reset
//   row_n        output  4  row drive, active-low, one bit low
//   col_n        input   4  column sense, active-low, asynchronous
//   clear        input      synchronous clear of value and digit_count
//   value        output 32  accumulated hex digits, newest in [3:0]
//   key_code     output  4  code of the last accepted key
//   key_valid    output     one-cycle pulse per accepted key
//   digit_count  output  4  digits since clear, saturating at 8

module keypad_scanner
    import kp_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  row_n,
    input  logic [3:0]  col_n,
    input  logic        clear,
    output logic [31:0] value,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic [3:0]  digit_count
);

    localparam int          DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [15:0] DEB   = 16'(DEBOUNCE);

    logic [DIV_W-1:0] div;
    logic [1:0]       row_idx;
    logic [3:0]       col_sync;
    logic             terminal;
    logic             frame_end;

    logic [3:0]       col_low;
    logic [2:0]       row_hits;
    logic [1:0]       row_col;
    logic [1:0]       hits_now;
    logic [2:0]       hits_sum;
    logic [1:0]       merged_hits;
    logic [3:0]       merged_code;
    logic [1:0]       acc_hits;
    logic [3:0]       acc_code;
    frame_t           frame_result;

    state_t           state;
    state_t           state_next;
    logic [3:0]       cand;
    logic [3:0]       cand_next;
    logic [15:0]      cnt;
    logic [15:0]      cnt_next;
    logic [15:0]      cnt_inc;
    logic             accept;

    sync2 #(
        .WIDTH    (COLS),
        .RESET_VAL(4'b1111)
    ) u_col_sync (
        .clk(clk),
        .rst(rst),
        .d  (col_n),
        .q  (col_sync)
    );

    assign row_n     = ROW_DRIVE[row_idx];
    assign terminal  = (div == DIV_W'(SCAN_DIV - 1));
    assign frame_end = terminal && (row_idx == 2'd3);

    // Row timing: the divider counts the row period, and the row index
    // moves on at the same edge that samples the finishing row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div     <= '0;
            row_idx <= 2'd0;
        end else if (terminal) begin
            div     <= '0;
            row_idx <= row_idx + 2'd1;
        end else begin
            div     <= div + DIV_W'(1);
        end
    end

    // Merge the current row's sample into the running frame tally. Hit
    // counts saturate at 2 because anything beyond one is already MULTI.
    always_comb begin
        col_low     = ~col_sync;
        row_hits    = count_low(col_low);
        row_col     = lowest_index(col_low);
        hits_now    = 2'd0;
        if (row_hits == 3'd1) begin
            hits_now = 2'd1;
        end else if (row_hits >= 3'd2) begin
            hits_now = 2'd2;
        end
        hits_sum    = {1'b0, acc_hits} + {1'b0, hits_now};
        merged_hits = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
        merged_code = acc_code;
        if ((row_hits == 3'd1) && (acc_hits == 2'd0)) begin
            merged_code = {row_idx, row_col};
        end
        case (merged_hits)
            2'd0:    frame_result = NONE;
            2'd1:    frame_result = ONE;
            default: frame_result = MULTI;
        endcase
    end

    // Frame accumulators restart after the row-3 sample has been consumed
    // by the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_hits <= 2'd0;
            acc_code <= 4'd0;
        end else if (terminal) begin
            if (row_idx == 2'd3) begin
                acc_hits <= 2'd0;
                acc_code <= 4'd0;
            end else begin
                acc_hits <= merged_hits;
                acc_code <= merged_code;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cand  <= 4'd0;
            cnt   <= 16'd0;
        end else begin
            state <= state_next;
            cand  <= cand_next;
            cnt   <= cnt_next;
        end
    end

    // Debounce FSM, stepped only at the end of each frame. With
    // DEBOUNCE == 1 the PRESS and RELEASE states are skipped entirely.
    always_comb begin
        state_next = state;
        cand_next  = cand;
        cnt_next   = cnt;
        accept     = 1'b0;
        cnt_inc    = cnt + 16'd1;
        if (frame_end) begin
            case (state)
                IDLE: begin
                    if (frame_result == ONE) begin
                        cand_next = merged_code;
                        cnt_next  = 16'd1;
                        if (DEB == 16'd1) begin
                            accept     = 1'b1;
                            state_next = HELD;
                        end else begin
                            state_next = PRESS;
                        end
                    end
                end
                PRESS: begin
                    if (frame_result == ONE) begin
                        if (merged_code == cand) begin
                            cnt_next = cnt_inc;
                            if (cnt_inc >= DEB) begin
                                accept     = 1'b1;
                                state_next = HELD;
                            end
                        end else begin
                            cand_next = merged_code;
                            cnt_next  = 16'd1;
                        end
                    end else begin
                        state_next = IDLE;
                    end
                end
                HELD: begin
                    if (frame_result == NONE) begin
                        cnt_next   = 16'd1;
                        state_next = (DEB == 16'd1) ? IDLE : RELEASE;
                    end
                end
                RELEASE: begin
                    if (frame_result == NONE) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc >= DEB) begin
                            state_next = IDLE;
                        end
                    end else begin
                        state_next = HELD;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Output registers. clear takes priority over an accept for the
    // digit buffer, but the key event itself is still reported.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value       <= 32'd0;
            key_code    <= 4'd0;
            key_valid   <= 1'b0;
            digit_count <= 4'd0;
        end else begin
            key_valid <= accept;
            if (accept) begin
                key_code <= merged_code;
            end
            if (clear) begin
                value       <= 32'd0;
                digit_count <= 4'd0;
            end else if (accept) begin
                value <= {value[27:0], merged_code};
                if (digit_count < 4'(MAX_DIGITS)) begin
                    digit_count <= digit_count + 4'd1;
                end
            end
        end
    end

endmodule
